core_cp15_fault_unit: RTL and testbench
=======================================

CORE_CP15_FAULT_UNIT -- requirements
Module: core_cp15_fault_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 dfault_valid / dfault_ready  in / out  1 / 1  MMU data-fault report handshake.
REQ-005 dfault_addr  in  30 (ptr)  faulting word address.
REQ-006 dfault_status  in  4  fault status code.
REQ-007 dfault_domain  in  4  faulting domain.
REQ-008 ifault_valid / ifault_ready  in / out  1 / 1  prefetch-fault report handshake.
REQ-009 ifault_status  in  4  prefetch fault status code.
REQ-010 flush  in  1  pipeline flush; discards uncommitted faults.
REQ-011 abort_take  in  1  core entering an abort exception this cycle.
REQ-012 abort_data  in  1  kind of abort_take: 1 = data, 0 = prefetch.
REQ-013 pending_dabort / pending_pabort  out  1 / 1  data / prefetch slot occupied.
REQ-014 fault_register  out  1  one-cycle pulse to the FAR stage.
REQ-015 fault_addr  out  30 (ptr)  address for the FAR stage; valid while fault_register is high.
REQ-016 load, transfer  in  1  CP15 access to FSR: read when load = 1, write when load = 0.
REQ-017 write  in  32 (word)  FSR write data.
REQ-018 fsr  out  32 (word)  FSR read value.
REQ-019 ifsr  out  32 (word)  IFSR read value; exists only under CP15_IFSR_EN.

Function
REQ-020 Each fault kind SHALL have a single-entry slot holding valid, status, plus addr and domain for the data slot.
REQ-021 Each ready output SHALL be exactly !slot_valid && !flush && !rst.
REQ-022 When valid && ready on a cycle, the slot SHALL latch the inputs at that edge, and pending_* SHALL go high the next cycle.
REQ-023 pending_dabort and pending_pabort SHALL equal their respective slot valid bits.
REQ-024 Both slots MAY be pending at once; the block SHALL NOT prioritise between them, because the core selects via abort_data.
REQ-025 Data commit: when abort_take && abort_data && pending_dabort, the block SHALL do the following at that edge: clear the slot, drive fault_register = 1 for exactly the next cycle, set fault_addr = slot addr, and set fsr = {23'b0, 1'b0, domain, status}.
REQ-026 Prefetch commit: when abort_take && !abort_data && pending_pabort, the block SHALL clear the slot, and fault_register and fsr SHALL be unaffected.
REQ-027 When abort_take has no matching pending slot, the block SHALL ignore it, with no state change.
REQ-028 flush SHALL clear both slots at the edge, except that the slot named by a simultaneous valid abort_take commits normally while the other slot clears.
REQ-029 The block SHALL NOT accept a new report in a flush cycle, which follows from ready being low.
REQ-030 A slot freed by a commit SHALL NOT accept a new report until the following cycle, which follows from ready being derived from registered valid.
REQ-031 FSR write: transfer && !load SHALL set fsr = {23'b0, write[8:0]}.
REQ-032 When an FSR write and a data commit occur on the same edge, the commit SHALL win.
REQ-033 fault_addr SHALL hold its last committed value between pulses.
REQ-034 fault_register SHALL be registered, never combinational from inputs.

Reset
REQ-035 When rst is high at an edge, the block SHALL clear both slots and set fault_register = 0, fault_addr = 0, fsr = 0, ifsr = 0.
REQ-036 rst SHALL override all other inputs, including a commit in progress.
REQ-037 ready outputs SHALL be 0 while rst is high and SHALL go to 1 in the first cycle after rst deasserts.

Configuration
REQ-038 The macro CP15_IFSR_EN SHALL select IFSR support.
REQ-039 With CP15_IFSR_EN defined, ifsr SHALL exist, a prefetch commit SHALL set ifsr = {28'b0, status}, and ifsr SHALL be read-only to CP15.
REQ-040 Without CP15_IFSR_EN, the ifsr port and register SHALL be absent, and prefetch commits SHALL record no status.

Verification
REQ-041 Data fault: report addr 0x0000_1234, status 0x5, domain 0x3, then abort_take with abort_data = 1 two cycles later -> one-cycle fault_register pulse, fault_addr = 0x0000_1234, fsr = 0x0000_0035, pending_dabort low.
REQ-042 Back-pressure: a second data report while pending -> dfault_ready = 0, and the first report is retained unchanged.
REQ-043 Flush: pending data fault, then flush -> pending_dabort = 0, no fault_register pulse, and a later abort_take is ignored.
REQ-044 Simultaneous: abort_take (data) with FSR write 0xFF in the same cycle -> fsr = the committed fault value, not 0xFF.
REQ-045 Both pending: abort_take with abort_data = 0 -> pending_pabort clears, pending_dabort stays set, no fault_register pulse, and ifsr = {28'b0, status} under CP15_IFSR_EN.
REQ-046 Reset mid-operation: rst in the cycle of a data commit -> fault_register = 0, fsr = 0, both slots empty the next cycle.

Source files
------------

// File: rtl/core_cp15_fault_unit.sv
// core_cp15_fault_unit
//
// Captures MMU data-fault and prefetch-fault reports into one single-entry
// slot per fault kind. When the core takes an abort, the matching slot
// commits. A data commit pulses fault_register for one cycle, presents the
// faulting address to the FAR stage and loads the FSR. A prefetch commit
// only frees its slot, and also loads the IFSR when that register is built.
// A pipeline flush discards slots that have not committed.
//
// Build option: define CP15_IFSR_EN to add the IFSR register and ifsr port.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   dfault_*         data-fault report handshake: addr, status, domain
//   ifault_*         prefetch-fault report handshake: status
//   flush            discard uncommitted faults
//   abort_take       core enters an abort exception this cycle
//   abort_data       abort kind: 1 = data, 0 = prefetch
//   pending_dabort   data slot occupied
//   pending_pabort   prefetch slot occupied
//   fault_register   one-cycle pulse to the FAR stage
//   fault_addr       FAR address, held between pulses
//   load, transfer   CP15 FSR access: write when transfer && !load
//   write            FSR write data
//   fsr              FSR read value
//   ifsr             IFSR read value (CP15_IFSR_EN only)
module core_cp15_fault_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        dfault_valid,
  output logic        dfault_ready,
  input  logic [29:0] dfault_addr,
  input  logic [3:0]  dfault_status,
  input  logic [3:0]  dfault_domain,
  input  logic        ifault_valid,
  output logic        ifault_ready,
  input  logic [3:0]  ifault_status,
  input  logic        flush,
  input  logic        abort_take,
  input  logic        abort_data,
  output logic        pending_dabort,
  output logic        pending_pabort,
  output logic        fault_register,
  output logic [29:0] fault_addr,
  input  logic        load,
  input  logic        transfer,
  input  logic [31:0] write,
`ifdef CP15_IFSR_EN
  output logic [31:0] fsr,
  output logic [31:0] ifsr
`else
  output logic [31:0] fsr
`endif
);

  logic        dslot_vld;
  logic [29:0] dslot_addr;
  logic [3:0]  dslot_status;
  logic [3:0]  dslot_domain;
  logic        pslot_vld;

  logic d_take;
  logic p_take;
  logic d_commit;
  logic p_commit;
  logic fsr_wr;

  // Only write[8:0] reaches the FSR; the upper bits are ignored.
  logic unused_write_hi;
  assign unused_write_hi = ^write[31:9];

  // Ready comes from the registered slot valid, so a slot freed by a commit
  // accepts a new report no earlier than the following cycle.
  assign dfault_ready = !dslot_vld && !flush && !rst;
  assign ifault_ready = !pslot_vld && !flush && !rst;

  assign d_take   = dfault_valid && dfault_ready;
  assign p_take   = ifault_valid && ifault_ready;
  assign d_commit = abort_take && abort_data && dslot_vld;
  assign p_commit = abort_take && !abort_data && pslot_vld;
  assign fsr_wr   = transfer && !load;

  assign pending_dabort = dslot_vld;
  assign pending_pabort = pslot_vld;

  // Slot valid bits. A commit takes precedence over flush, which lets the
  // slot chosen by a same-cycle abort_take commit while the other clears.
  // A take and a commit never coincide on one slot because ready requires
  // the slot to be empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      dslot_vld <= 1'b0;
      pslot_vld <= 1'b0;
    end else begin
      if (d_commit || flush) dslot_vld <= 1'b0;
      else if (d_take)       dslot_vld <= 1'b1;

      if (p_commit || flush) pslot_vld <= 1'b0;
      else if (p_take)       pslot_vld <= 1'b1;
    end
  end

  // Slot payload is only meaningful while the slot is valid, so it is not reset.
  always_ff @(posedge clk) begin
    if (d_take) begin
      dslot_addr   <= dfault_addr;
      dslot_status <= dfault_status;
      dslot_domain <= dfault_domain;
    end
  end

  // Commit outputs. A data commit overrides a same-cycle CP15 FSR write.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_register <= 1'b0;
      fault_addr     <= '0;
      fsr            <= '0;
    end else begin
      fault_register <= d_commit;
      if (d_commit) begin
        fault_addr <= dslot_addr;
        fsr        <= {23'b0, 1'b0, dslot_domain, dslot_status};
      end else if (fsr_wr) begin
        fsr <= {23'b0, write[8:0]};
      end
    end
  end

`ifdef CP15_IFSR_EN
  logic [3:0] pslot_status;

  always_ff @(posedge clk) begin
    if (p_take) pslot_status <= ifault_status;
  end

  // The IFSR is loaded only by a prefetch commit; CP15 cannot write it.
  always_ff @(posedge clk) begin
    if (rst)           ifsr <= '0;
    else if (p_commit) ifsr <= {28'b0, pslot_status};
  end
`else
  // Without an IFSR, prefetch status has nowhere to be recorded.
  logic unused_ifault_status;
  assign unused_ifault_status = ^ifault_status;
`endif

endmodule

// File: tb/tb_core_cp15_fault_unit.sv
module tb_core_cp15_fault_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        dfault_valid;
  logic        dfault_ready;
  logic [29:0] dfault_addr;
  logic [3:0]  dfault_status;
  logic [3:0]  dfault_domain;
  logic        ifault_valid;
  logic        ifault_ready;
  logic [3:0]  ifault_status;
  logic        flush;
  logic        abort_take;
  logic        abort_data;
  logic        pending_dabort;
  logic        pending_pabort;
  logic        fault_register;
  logic [29:0] fault_addr;
  logic        load;
  logic        transfer;
  logic [31:0] write;
  logic [31:0] fsr;
`ifdef CP15_IFSR_EN
  logic [31:0] ifsr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  core_cp15_fault_unit dut (
    .clk            (clk),
    .rst            (rst),
    .dfault_valid   (dfault_valid),
    .dfault_ready   (dfault_ready),
    .dfault_addr    (dfault_addr),
    .dfault_status  (dfault_status),
    .dfault_domain  (dfault_domain),
    .ifault_valid   (ifault_valid),
    .ifault_ready   (ifault_ready),
    .ifault_status  (ifault_status),
    .flush          (flush),
    .abort_take     (abort_take),
    .abort_data     (abort_data),
    .pending_dabort (pending_dabort),
    .pending_pabort (pending_pabort),
    .fault_register (fault_register),
    .fault_addr     (fault_addr),
    .load           (load),
    .transfer       (transfer),
    .write          (write),
`ifdef CP15_IFSR_EN
    .fsr            (fsr),
    .ifsr           (ifsr)
`else
    .fsr            (fsr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dfault_valid = 1'b0;
    ifault_valid = 1'b0;
    flush        = 1'b0;
    abort_take   = 1'b0;
    abort_data   = 1'b0;
    transfer     = 1'b0;
    load         = 1'b0;
    write        = '0;
  endtask

  task automatic drive_d(input logic [29:0] a, input logic [3:0] s, input logic [3:0] d);
    dfault_valid  = 1'b1;
    dfault_addr   = a;
    dfault_status = s;
    dfault_domain = d;
  endtask

  initial begin
    rst = 1'b1;
    dfault_addr = '0; dfault_status = '0; dfault_domain = '0; ifault_status = '0;
    idle();
    tick(); tick();
    // Reset state
    check("rst_dready", 32'(dfault_ready), 32'h0);
    check("rst_iready", 32'(ifault_ready), 32'h0);
    check("rst_freg", 32'(fault_register), 32'h0);
    check("rst_faddr", 32'(fault_addr), 32'h0);
    check("rst_fsr", fsr, 32'h0);
    check("rst_pend_d", 32'(pending_dabort), 32'h0);
    check("rst_pend_p", 32'(pending_pabort), 32'h0);
`ifdef CP15_IFSR_EN
    check("rst_ifsr", ifsr, 32'h0);
`endif
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(dfault_ready), 32'h1);
    check("iready_after_rst", 32'(ifault_ready), 32'h1);

    // Data fault with commit two cycles after the report
    drive_d(30'h0000_1234, 4'h5, 4'h3);
    tick();
    idle();
    check("t1_pend", 32'(pending_dabort), 32'h1);
    check("t1_ready_low", 32'(dfault_ready), 32'h0);
    tick();
    abort_take = 1'b1; abort_data = 1'b1;
    tick();
    idle();
    check("t1_freg", 32'(fault_register), 32'h1);
    check("t1_faddr", 32'(fault_addr), 32'h0000_1234);
    check("t1_fsr", fsr, 32'h0000_0035);
    check("t1_pend_clr", 32'(pending_dabort), 32'h0);
    check("t1_ready_back", 32'(dfault_ready), 32'h1);
    tick();
    check("t1_freg_1cyc", 32'(fault_register), 32'h0);
    check("t1_faddr_hold", 32'(fault_addr), 32'h0000_1234);

    // Back-pressure: a second report while the slot is full is refused
    drive_d(30'h0000_2AAA, 4'hA, 4'hC);
    tick();
    drive_d(30'h3FFF_FFFF, 4'h1, 4'h1);
    #1;
    check("t2_ready_low", 32'(dfault_ready), 32'h0);
    tick(); tick();
    idle();
    abort_take = 1'b1; abort_data = 1'b1;
    tick();
    idle();
    check("t2_faddr_kept", 32'(fault_addr), 32'h0000_2AAA);
    check("t2_fsr_kept", fsr, 32'h0000_00CA);

    // Flush discards a pending fault and refuses new reports
    drive_d(30'h0000_0055, 4'h2, 4'h4);
    tick();
    idle();
    flush = 1'b1;
    ifault_valid = 1'b1; ifault_status = 4'h7;
    #1;
    check("t3_iready_flush", 32'(ifault_ready), 32'h0);
    tick();
    idle();
    check("t3_pend_d", 32'(pending_dabort), 32'h0);
    check("t3_pend_p", 32'(pending_pabort), 32'h0);
    abort_take = 1'b1; abort_data = 1'b1;
    tick();
    idle();
    check("t3_no_pulse", 32'(fault_register), 32'h0);
    check("t3_faddr_same", 32'(fault_addr), 32'h0000_2AAA);
    check("t3_fsr_same", fsr, 32'h0000_00CA);

    // Commit beats a same-cycle FSR write
    drive_d(30'h0000_0100, 4'hF, 4'h9);
    tick();
    idle();
    abort_take = 1'b1; abort_data = 1'b1;
    transfer = 1'b1; load = 1'b0; write = 32'h0000_00FF;
    tick();
    idle();
    check("t4_freg", 32'(fault_register), 32'h1);
    check("t4_fsr_commit", fsr, 32'h0000_009F);
    // Plain FSR write keeps only write[8:0]
    transfer = 1'b1; load = 1'b0; write = 32'hFFFF_FE5A;
    tick();
    idle();
    check("t4_fsr_write", fsr, 32'h0000_005A);
    // A CP15 read does not modify the FSR
    transfer = 1'b1; load = 1'b1; write = 32'h0000_0123;
    tick();
    idle();
    check("t4_fsr_read", fsr, 32'h0000_005A);

    // Both pending: prefetch commit leaves the data slot alone
    drive_d(30'h0000_0777, 4'h6, 4'h1);
    ifault_valid = 1'b1; ifault_status = 4'hD;
    tick();
    idle();
    check("t5_both_d", 32'(pending_dabort), 32'h1);
    check("t5_both_p", 32'(pending_pabort), 32'h1);
    abort_take = 1'b1; abort_data = 1'b0;
    tick();
    idle();
    check("t5_p_clr", 32'(pending_pabort), 32'h0);
    check("t5_d_stay", 32'(pending_dabort), 32'h1);
    check("t5_no_pulse", 32'(fault_register), 32'h0);
    check("t5_fsr_same", fsr, 32'h0000_005A);
`ifdef CP15_IFSR_EN
    check("t5_ifsr", ifsr, 32'h0000_000D);
`endif
    abort_take = 1'b1; abort_data = 1'b1;
    tick();
    idle();
    check("t5_d_commit", fsr, 32'h0000_0016);
    check("t5_d_addr", 32'(fault_addr), 32'h0000_0777);

    // Flush with a data commit: data commits, prefetch slot clears
    drive_d(30'h0000_0444, 4'h7, 4'h5);
    ifault_valid = 1'b1; ifault_status = 4'hB;
    tick();
    idle();
    abort_take = 1'b1; abort_data = 1'b1; flush = 1'b1;
    tick();
    idle();
    check("t6_freg", 32'(fault_register), 32'h1);
    check("t6_faddr", 32'(fault_addr), 32'h0000_0444);
    check("t6_fsr", fsr, 32'h0000_0057);
    check("t6_pend_d", 32'(pending_dabort), 32'h0);
    check("t6_pend_p", 32'(pending_pabort), 32'h0);
`ifdef CP15_IFSR_EN
    check("t6_ifsr_same", ifsr, 32'h0000_000D);
`endif
    tick();

    // Reset in the cycle of a data commit
    drive_d(30'h0000_0999, 4'h3, 4'h2);
    ifault_valid = 1'b1; ifault_status = 4'h4;
    tick();
    idle();
    abort_take = 1'b1; abort_data = 1'b1; rst = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    check("t7_freg", 32'(fault_register), 32'h0);
    check("t7_fsr", fsr, 32'h0);
    check("t7_faddr", 32'(fault_addr), 32'h0);
    check("t7_pend_d", 32'(pending_dabort), 32'h0);
    check("t7_pend_p", 32'(pending_pabort), 32'h0);
`ifdef CP15_IFSR_EN
    check("t7_ifsr", ifsr, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
